// File: rtl/ising_observable_accumulator_if.sv
// Sample/result bus for the Ising observable accumulator.
// The master side feeds samples and acknowledges results; the slave side is the accumulator.
interface ising_observable_accumulator_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int WINDOW_LOG2 = 4
);
    logic                          enable;
    logic                          clear;
    logic                          sample_valid;
    logic signed [DATA_WIDTH-1:0]  energy;
    logic signed [DATA_WIDTH-1:0]  magnetization;
    logic                          result_valid;
    logic                          result_ready;
    logic signed [DATA_WIDTH-1:0]  avg_energy;
    logic [DATA_WIDTH-1:0]         avg_abs_mag;
    logic signed [DATA_WIDTH-1:0]  min_energy;
    logic signed [DATA_WIDTH-1:0]  max_energy;
    logic [2*DATA_WIDTH-1:0]       avg_energy_sq;
    logic [2*DATA_WIDTH-1:0]       avg_mag_sq;
    logic [WINDOW_LOG2-1:0]        sample_count;
    logic                          busy;
    logic                          overrun;

    modport master (
        output enable, clear, sample_valid, energy, magnetization, result_ready,
        input  result_valid, avg_energy, avg_abs_mag, min_energy, max_energy,
               avg_energy_sq, avg_mag_sq, sample_count, busy, overrun
    );

    modport slave (
        input  enable, clear, sample_valid, energy, magnetization, result_ready,
        output result_valid, avg_energy, avg_abs_mag, min_energy, max_energy,
               avg_energy_sq, avg_mag_sq, sample_count, busy, overrun
    );
endinterface

// File: rtl/ising_observable_accumulator.sv
// Windowed mean/extrema accumulator for Ising energy and magnetization samples.
// Optional second moments (E^2, M^2 means) are built when ISING_SQ_MOMENTS_EN is defined.
module ising_observable_accumulator #(
    parameter int DATA_WIDTH  = 16,
    parameter int WINDOW_LOG2 = 4
) (
    input  logic clk,
    input  logic rst,
    ising_observable_accumulator_if.slave bus
);
    localparam int SUM_W = DATA_WIDTH + WINDOW_LOG2;
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]        MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state_reg, state_next;

    logic                          accept;
    logic                          closing;
    logic [WINDOW_LOG2-1:0]        count_reg;
    logic signed [SUM_W-1:0]       e_sum_reg;
    logic [SUM_W-1:0]              m_sum_reg;
    logic signed [SUM_W-1:0]       e_total;
    logic [SUM_W-1:0]              m_total;
    logic [DATA_WIDTH-1:0]         abs_mag;
    logic signed [DATA_WIDTH-1:0]  min_reg, max_reg, min_cur, max_cur;
    logic signed [DATA_WIDTH-1:0]  avg_energy_reg, min_energy_reg, max_energy_reg;
    logic [DATA_WIDTH-1:0]         avg_abs_mag_reg;
    logic                          result_valid_reg;
    logic                          overrun_reg;

    assign accept  = bus.sample_valid & bus.enable & ~bus.clear;
    assign closing = accept && (count_reg == {WINDOW_LOG2{1'b1}});

    // |M| of the most negative code has no positive twin, so it saturates.
    always_comb begin
        abs_mag = bus.magnetization;
        if (bus.magnetization[DATA_WIDTH-1]) begin
            if (bus.magnetization == MOST_NEG)
                abs_mag = MOST_POS;
            else
                abs_mag = DATA_WIDTH'(-bus.magnetization);
        end
    end

    assign e_total = e_sum_reg + SUM_W'(bus.energy);
    assign m_total = m_sum_reg + SUM_W'(abs_mag);

    always_comb begin
        min_cur = min_reg;
        max_cur = max_reg;
        if (count_reg == '0) begin
            min_cur = bus.energy;
            max_cur = bus.energy;
        end else begin
            if (bus.energy < min_reg) min_cur = bus.energy;
            if (bus.energy > max_reg) max_cur = bus.energy;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ACCUM;
            ACCUM:   if (bus.clear || closing) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy = (state_reg == ACCUM);
    end

    // Window accumulation; closing sample folds straight into the result, not the sums.
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            count_reg <= '0;
            e_sum_reg <= '0;
            m_sum_reg <= '0;
            min_reg   <= '0;
            max_reg   <= '0;
        end else if (accept) begin
            if (closing) begin
                count_reg <= '0;
                e_sum_reg <= '0;
                m_sum_reg <= '0;
                min_reg   <= '0;
                max_reg   <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
                e_sum_reg <= e_total;
                m_sum_reg <= m_total;
                min_reg   <= min_cur;
                max_reg   <= max_cur;
            end
        end
    end

    // Taking the top DATA_WIDTH bits above the shift equals an arithmetic/logical shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            avg_energy_reg  <= '0;
            avg_abs_mag_reg <= '0;
            min_energy_reg  <= '0;
            max_energy_reg  <= '0;
        end else if (closing) begin
            avg_energy_reg  <= e_total[WINDOW_LOG2 +: DATA_WIDTH];
            avg_abs_mag_reg <= m_total[WINDOW_LOG2 +: DATA_WIDTH];
            min_energy_reg  <= min_cur;
            max_energy_reg  <= max_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            result_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            if (closing)
                result_valid_reg <= 1'b1;
            else if (result_valid_reg && bus.result_ready)
                result_valid_reg <= 1'b0;
            if (closing && result_valid_reg && !bus.result_ready)
                overrun_reg <= 1'b1;
        end
    end

`ifdef ISING_SQ_MOMENTS_EN
    localparam int SQ_W = 2*DATA_WIDTH + WINDOW_LOG2;

    logic signed [2*DATA_WIDTH-1:0] e_prod, m_prod;
    logic [SQ_W-1:0]                e_sq_sum_reg, m_sq_sum_reg;
    logic [SQ_W-1:0]                e_sq_total, m_sq_total;
    logic [2*DATA_WIDTH-1:0]        avg_energy_sq_reg, avg_mag_sq_reg;

    // Squares of signed values are non-negative and fit in 2*DATA_WIDTH unsigned bits.
    assign e_prod     = bus.energy * bus.energy;
    assign m_prod     = bus.magnetization * bus.magnetization;
    assign e_sq_total = e_sq_sum_reg + SQ_W'($unsigned(e_prod));
    assign m_sq_total = m_sq_sum_reg + SQ_W'($unsigned(m_prod));

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            e_sq_sum_reg <= '0;
            m_sq_sum_reg <= '0;
        end else if (accept) begin
            e_sq_sum_reg <= closing ? '0 : e_sq_total;
            m_sq_sum_reg <= closing ? '0 : m_sq_total;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avg_energy_sq_reg <= '0;
            avg_mag_sq_reg    <= '0;
        end else if (closing) begin
            avg_energy_sq_reg <= e_sq_total[WINDOW_LOG2 +: 2*DATA_WIDTH];
            avg_mag_sq_reg    <= m_sq_total[WINDOW_LOG2 +: 2*DATA_WIDTH];
        end
    end

    assign bus.avg_energy_sq = avg_energy_sq_reg;
    assign bus.avg_mag_sq    = avg_mag_sq_reg;
`else
    assign bus.avg_energy_sq = '0;
    assign bus.avg_mag_sq    = '0;
`endif

    assign bus.result_valid = result_valid_reg;
    assign bus.overrun      = overrun_reg;
    assign bus.sample_count = count_reg;
    assign bus.avg_energy   = avg_energy_reg;
    assign bus.avg_abs_mag  = avg_abs_mag_reg;
    assign bus.min_energy   = min_energy_reg;
    assign bus.max_energy   = max_energy_reg;
endmodule

// File: tb/tb_ising_observable_accumulator.sv
// Directed bench for ising_observable_accumulator with a 4-sample window.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_ising_observable_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ising_observable_accumulator_if #(.DATA_WIDTH(16), .WINDOW_LOG2(2)) bus ();

    ising_observable_accumulator #(.DATA_WIDTH(16), .WINDOW_LOG2(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic send(input int e, input int m);
        @(negedge clk);
        bus.sample_valid  = 1'b1;
        bus.energy        = 16'(e);
        bus.magnetization = 16'(m);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.result_ready = 1'b0;
        bus.clear        = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    task automatic check_window(input string name, input int ae, input int am,
                                input int mn, input int mx,
                                input logic [31:0] esq, input logic [31:0] msq);
        logic [31:0] want_esq, want_msq;
`ifdef ISING_SQ_MOMENTS_EN
        want_esq = esq;
        want_msq = msq;
`else
        want_esq = 32'd0;
        want_msq = 32'd0;
`endif
        $display("window %s: avg_e=%0d avg_m=%0d min=%0d max=%0d esq=%0d msq=%0d rv=%0b",
                 name, bus.avg_energy, bus.avg_abs_mag, bus.min_energy, bus.max_energy,
                 bus.avg_energy_sq, bus.avg_mag_sq, bus.result_valid);
        total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL %s result_valid got=%0b want=1", name, bus.result_valid); end
        total++; if ($signed(bus.avg_energy) !== ae) begin bad++; $display("FAIL %s avg_energy got=%0d want=%0d", name, bus.avg_energy, ae); end
        total++; if (int'(bus.avg_abs_mag) !== am) begin bad++; $display("FAIL %s avg_abs_mag got=%0d want=%0d", name, bus.avg_abs_mag, am); end
        total++; if ($signed(bus.min_energy) !== mn) begin bad++; $display("FAIL %s min_energy got=%0d want=%0d", name, bus.min_energy, mn); end
        total++; if ($signed(bus.max_energy) !== mx) begin bad++; $display("FAIL %s max_energy got=%0d want=%0d", name, bus.max_energy, mx); end
        total++; if (bus.avg_energy_sq !== want_esq) begin bad++; $display("FAIL %s avg_energy_sq got=%0d want=%0d", name, bus.avg_energy_sq, want_esq); end
        total++; if (bus.avg_mag_sq !== want_msq) begin bad++; $display("FAIL %s avg_mag_sq got=%0d want=%0d", name, bus.avg_mag_sq, want_msq); end
        total++; if (bus.sample_count !== 2'd0) begin bad++; $display("FAIL %s sample_count got=%0d want=0", name, bus.sample_count); end
    endtask

    task automatic check_all_zero(input string name);
        logic [31:0] flat;
        flat = {15'd0, bus.result_valid, bus.overrun, bus.busy, bus.sample_count, 12'd0};
        $display("%s: rv=%0b ovr=%0b busy=%0b cnt=%0d", name, bus.result_valid, bus.overrun, bus.busy, bus.sample_count);
        total++; if (flat !== 32'd0) begin bad++; $display("FAIL %s flags got=%h want=0", name, flat); end
        total++; if (bus.avg_energy !== 16'd0 || bus.avg_abs_mag !== 16'd0) begin bad++; $display("FAIL %s averages got=%0d/%0d want=0/0", name, bus.avg_energy, bus.avg_abs_mag); end
        total++; if (bus.min_energy !== 16'd0 || bus.max_energy !== 16'd0) begin bad++; $display("FAIL %s extrema got=%0d/%0d want=0/0", name, bus.min_energy, bus.max_energy); end
        total++; if (bus.avg_energy_sq !== 32'd0 || bus.avg_mag_sq !== 32'd0) begin bad++; $display("FAIL %s squares got=%0d/%0d want=0/0", name, bus.avg_energy_sq, bus.avg_mag_sq); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    task automatic test_basic();
        send(-32, 16); send(-24, -16); send(-16, 8); send(-8, -8);
        idle_cycle();
        check_window("basic", -20, 12, -32, -8, 32'd480, 32'd160);
        consume();
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL basic_consume result_valid got=%0b want=0", bus.result_valid); end
    endtask

    task automatic test_floor_sat();
        send(-1, -32768); send(0, -32768); send(0, -32768); send(0, -32768);
        idle_cycle();
        check_window("floor_sat", -1, 32767, -1, 0, 32'd0, 32'd1073741824);
        consume();
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 4; i++) send(4, 1);
        for (int i = 0; i < 4; i++) send(8, 2);
        idle_cycle();
        check_window("overrun", 8, 2, 8, 8, 32'd64, 32'd4);
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_set overrun got=%0b want=1", bus.overrun); end
        consume();
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL overrun_consume result_valid got=%0b want=0", bus.result_valid); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky overrun got=%0b want=1", bus.overrun); end
    endtask

    task automatic test_pause_clear();
        send(1, 1); send(1, 1);
        idle_cycle();
        total++; if (bus.sample_count !== 2'd2 || bus.busy !== 1'b1) begin bad++; $display("FAIL pause_pre cnt/busy got=%0d/%0b want=2/1", bus.sample_count, bus.busy); end
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin send(100, 100); idle_cycle(); end
        $display("pause: cnt=%0d busy=%0b", bus.sample_count, bus.busy);
        total++; if (bus.sample_count !== 2'd2 || bus.busy !== 1'b1) begin bad++; $display("FAIL pause_hold cnt/busy got=%0d/%0b want=2/1", bus.sample_count, bus.busy); end
        bus.enable = 1'b1;
        @(negedge clk);
        bus.clear = 1'b1;
        bus.sample_valid = 1'b1;
        idle_cycle();
        $display("clear: cnt=%0d busy=%0b ovr=%0b rv=%0b", bus.sample_count, bus.busy, bus.overrun, bus.result_valid);
        total++; if (bus.sample_count !== 2'd0 || bus.busy !== 1'b0) begin bad++; $display("FAIL clear cnt/busy got=%0d/%0b want=0/0", bus.sample_count, bus.busy); end
        total++; if (bus.overrun !== 1'b0 || bus.result_valid !== 1'b0) begin bad++; $display("FAIL clear ovr/rv got=%0b/%0b want=0/0", bus.overrun, bus.result_valid); end
        total++; if ($signed(bus.avg_energy) !== 8) begin bad++; $display("FAIL clear_keeps avg_energy got=%0d want=8", bus.avg_energy); end
        // a fresh window after clear must not include the two pre-clear samples
        for (int i = 0; i < 4; i++) send(-4, 3);
        idle_cycle();
        check_window("after_clear", -4, 3, -4, -4, 32'd16, 32'd9);
        consume();
    endtask

    task automatic test_close_ready();
        for (int i = 0; i < 4; i++) send(2, 0);
        idle_cycle();
        check_window("close_ready_w1", 2, 0, 2, 2, 32'd4, 32'd0);
        send(6, 5); send(6, 5); send(6, 5);
        send(6, 5);
        bus.result_ready = 1'b1;
        idle_cycle();
        check_window("close_ready_w2", 6, 5, 6, 6, 32'd36, 32'd25);
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL close_ready overrun got=%0b want=0", bus.overrun); end
        consume();
    endtask

    task automatic test_reset_mid();
        send(100, 7); send(100, 7); send(100, 7);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset_mid");
        send(10, 1); send(20, -2); send(30, 3); send(40, -4);
        idle_cycle();
        check_window("reset_mid_fresh", 25, 2, 10, 40, 32'd750, 32'd7);
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_mid overrun got=%0b want=0", bus.overrun); end
    endtask

    initial begin
        bus.enable        = 1'b1;
        bus.clear         = 1'b0;
        bus.sample_valid  = 1'b0;
        bus.energy        = '0;
        bus.magnetization = '0;
        bus.result_ready  = 1'b0;
        test_reset();
        test_basic();
        test_floor_sat();
        test_overrun();
        test_pause_clear();
        test_close_ready();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ising_observable_accumulator.md
# ising_observable_accumulator

Windowed observable accumulator for the 2D Ising lattice engine. Once per sample (one pulse per lattice update), it takes the system energy and magnetization. Over each window of 2^WINDOW_LOG2 samples it produces the mean energy, mean |magnetization|, energy min/max and, optionally, second moments for specific-heat and susceptibility estimates. It sits between the lattice top level and the host readout, and replaces ad-hoc bench-side averaging with a synthesizable, parametrised measurement unit that has a valid/ready result handshake.

## Interface
- DATA_WIDTH, 16, signed width of energy/magnetization samples
- WINDOW_LOG2, 4, window length is 2^WINDOW_LOG2 samples (1..12)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  gates sample acceptance (low = pause, partial window held)
- clear  in  1  synchronous flush of window, results and flags
- sample_valid  in  1  one-cycle pulse per lattice update
- energy  in  DATA_WIDTH  signed system energy
- magnetization  in  DATA_WIDTH  signed system magnetization
- result_valid  out  1  result set available
- result_ready  in  1  host accepts result set
- avg_energy  out  DATA_WIDTH  signed window mean
- avg_abs_mag  out  DATA_WIDTH  unsigned window mean of |M|
- min_energy / max_energy  out  DATA_WIDTH  signed window extrema
- avg_energy_sq / avg_mag_sq  out  2*DATA_WIDTH  unsigned window means of E², M² (macro only)
- sample_count  out  WINDOW_LOG2  samples accepted in current window
- busy  out  1  window in progress
- overrun  out  1  sticky: an unread result was overwritten

## Operation
- A sample is accepted when sample_valid & enable & !clear.
- FSM states: IDLE, ACCUM.
  - IDLE→ACCUM: on the first accepted sample.
  - ACCUM→IDLE: on acceptance of sample 2^WINDOW_LOG2 (window close), or on clear.
  - busy = (state==ACCUM).
- Accumulators:
  - Energy sum: signed, DATA_WIDTH+WINDOW_LOG2 bits.
  - |M| sum: unsigned, same width. |−2^(DATA_WIDTH−1)| saturates to 2^(DATA_WIDTH−1)−1.
  - Square sums: unsigned, 2*DATA_WIDTH+WINDOW_LOG2 bits.
  - None of these sums can overflow.
- Averages are computed from (sum + closing sample) right-shifted by WINDOW_LOG2. The energy shift is arithmetic and floors toward −∞. The other shifts are logical.
- Min/max: the first sample of a window initialises both; subsequent samples update them by signed compare.
- At window close:
  - Result registers load; accumulators, min/max and sample_count reset.
  - A sample accepted on the following cycle starts the new window, so no sample is lost.
- Result handshake:
  - result_valid rises at window close and holds until result_valid & result_ready.
  - Window close while result_valid & !result_ready: overwrite the result, keep result_valid high, set overrun.
  - Window close with result_ready high in the same cycle: the old result is consumed, the new one is loaded, result_valid stays high, no overrun.
- enable low: the state and partial sums freeze; the result handshake continues.
- clear (priority over sample_valid):
  - Returns to IDLE.
  - Zeroes sums, sample_count and overrun.
  - Drops result_valid.
  - Result registers keep their values.

## Timing
- Reset values: result_valid=0, overrun=0, busy=0, sample_count=0, all result outputs=0, state=IDLE.
- Latency: closing sample accepted at edge t → result_valid=1 and results stable after edge t (visible in cycle t+1).
- sample_count increments on the edge that accepts a sample. It wraps to 0 at window close.
- Back-to-back sample_valid every cycle is supported at full rate.
- Reset mid-window: all partial state is discarded, with no result emitted.

## Configuration
- ISING_SQ_MOMENTS_EN defined:
  - E² and M² accumulators and their multipliers are built.
  - avg_energy_sq / avg_mag_sq carry window means.
- ISING_SQ_MOMENTS_EN undefined:
  - No multipliers or square accumulators are built.
  - avg_energy_sq / avg_mag_sq are tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- WINDOW_LOG2=2, enable=1, samples E={−32,−24,−16,−8}, M={16,−16,8,−8}, back-to-back → one cycle after the 4th sample, result_valid=1 with:
  - avg_energy=−20, avg_abs_mag=12, min=−32, max=−8
  - with macro: avg_energy_sq=480, avg_mag_sq=160
- Floor/saturation: E={−1,0,0,0}, M={−32768,−32768,−32768,−32768} → avg_energy=−1, avg_abs_mag=32767.
- Overrun: result_ready=0 across two complete windows → second results visible, result_valid=1, overrun=1. Then result_ready=1 for one cycle → result_valid=0, overrun stays 1.
- Pause/clear:
  - 2 samples, enable=0 with 5 sample_valid pulses → sample_count stays 2.
  - clear together with sample_valid → sample_count=0, busy=0, overrun=0, result_valid=0.
- Simultaneous close and ready: result_valid held from window 1, result_ready=1 on the cycle window 2 closes → window 2 results, result_valid=1, overrun=0.
- Reset mid-window: rst after 3 of 4 samples, then 4 fresh samples → only the fresh window is reported, and all outputs are 0 in the cycle after reset.
